// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiplier result path:
// default dimensions, result/row types and the capture FSM state enum.
package mvm_pkg;

   localparam int MAT_SCALE    = 20;
   localparam int INPUT_WIDTH  = 8;
   localparam int OUTPUT_WIDTH = 2 * INPUT_WIDTH;
   localparam int BUF_VECS     = 2;
   localparam int ROW_W        = $clog2(MAT_SCALE);

   typedef logic signed [OUTPUT_WIDTH-1:0] result_t;
   typedef logic [ROW_W-1:0]               row_idx_t;

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } cap_state_t;

endpackage

// File: rtl/result_ring_fifo.sv
// Parameterised ring FIFO with occupancy count.
// A push while full is dropped and leaves the write pointer in place.
// A pop while empty is ignored. Push and pop in the same cycle move
// both pointers and leave the count unchanged.
module result_ring_fifo #(
   parameter  int WIDTH = 21,
   parameter  int DEPTH = 40,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;
   logic [PTR_W-1:0] w_wr_ptr_next;
   logic [PTR_W-1:0] w_rd_ptr_next;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Pointer increment with wrap from DEPTH-1 back to 0.
   always_comb begin
      w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
      w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
      if (r_wr_ptr == PTR_W'(DEPTH - 1)) w_wr_ptr_next = '0;
      if (r_rd_ptr == PTR_W'(DEPTH - 1)) w_rd_ptr_next = '0;
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= w_wr_ptr_next;
         if (w_do_pop)  r_rd_ptr <= w_rd_ptr_next;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/mvm_result_collector.sv
// Captures the MAT_SCALE-word result burst that follows an MVM done strobe,
// buffers it in a ring FIFO and replays it on a valid/ready stream tagged
// with row index and last flag. space_avail tells the upstream controller
// whether a whole further vector fits.
//
// Stream handshake: out_valid is high whenever the buffer holds a word;
// the head word (out_data/out_index/out_last) is transferred on every
// rising edge where out_valid && out_ready, and stays stable otherwise.
module mvm_result_collector
   import mvm_pkg::*;
#(
   parameter int MAT_SCALE    = mvm_pkg::MAT_SCALE,
   parameter int INPUT_WIDTH  = mvm_pkg::INPUT_WIDTH,
   parameter int OUTPUT_WIDTH = 2 * INPUT_WIDTH,
   parameter int BUF_VECS     = mvm_pkg::BUF_VECS
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mvm_done,
   input  logic signed [OUTPUT_WIDTH-1:0] mvm_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [OUTPUT_WIDTH-1:0] out_data,
   output logic [$clog2(MAT_SCALE)-1:0]   out_index,
   output logic                           out_last,
   output logic                           space_avail,
   output logic                           overflow,
   output logic                           protocol_err,
   output cap_state_t                     dbg_state
);

   localparam int DEPTH = BUF_VECS * MAT_SCALE;
   localparam int IDX_W = $clog2(MAT_SCALE);
   localparam int ENT_W = OUTPUT_WIDTH + IDX_W;
   localparam int CNT_W = $clog2(DEPTH + 1);

   cap_state_t        r_state;
   cap_state_t        w_state_next;
   logic [IDX_W-1:0]  r_row;
   logic [IDX_W-1:0]  w_row_next;
   logic              w_push;
   logic              w_pop;
   logic [ENT_W-1:0]  w_push_ent;
   logic [ENT_W-1:0]  w_head_ent;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count;
   logic [IDX_W-1:0]  w_head_idx;
   logic              r_overflow;
   logic              r_protocol_err;

   // Entry layout: {data, row index}.
   assign w_push_ent = {mvm_data, r_row};
   assign w_head_idx = w_head_ent[IDX_W-1:0];
   assign w_pop      = out_valid && out_ready;

   result_ring_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_ent),
      .i_pop   (w_pop),
      .o_data  (w_head_ent),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Capture sequencing: done in IDLE starts a burst; CAPTURE writes one
   // word per cycle and returns to IDLE after row MAT_SCALE-1. A done
   // seen during CAPTURE does not restart the burst.
   always_comb begin
      w_state_next = r_state;
      w_row_next   = r_row;
      w_push       = 1'b0;
      case (r_state)
         IDLE: begin
            if (mvm_done) begin
               w_state_next = CAPTURE;
               w_row_next   = '0;
            end
         end
         CAPTURE: begin
            w_push = 1'b1;
            if (r_row == IDX_W'(MAT_SCALE - 1)) begin
               w_state_next = IDLE;
               w_row_next   = '0;
            end else begin
               w_row_next = r_row + IDX_W'(1);
            end
         end
         default: begin
            w_state_next = IDLE;
            w_row_next   = '0;
         end
      endcase
   end

   // State and row counter registers; reset discards a partial burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_row   <= '0;
      end else begin
         r_state <= w_state_next;
         r_row   <= w_row_next;
      end
   end

   // Sticky error flags: dropped capture word, and done during a burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow     <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         if (w_push && w_full)               r_overflow     <= 1'b1;
         if ((r_state == CAPTURE) && mvm_done) r_protocol_err <= 1'b1;
      end
   end

   // Stream outputs; data and index read as zero while the buffer is empty.
   always_comb begin
      out_valid   = !w_empty;
      out_data    = '0;
      out_index   = '0;
      out_last    = 1'b0;
      if (out_valid) begin
         out_data  = w_head_ent[ENT_W-1:IDX_W];
         out_index = w_head_idx;
         out_last  = (w_head_idx == IDX_W'(MAT_SCALE - 1));
      end
      space_avail = (w_count <= CNT_W'(DEPTH - MAT_SCALE));
   end

   assign overflow     = r_overflow;
   assign protocol_err = r_protocol_err;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_mvm_result_collector.sv
// Directed-sequence bench for mvm_result_collector with randomized data
// and consumer readiness, checked against a queue-based buffer model.
module tb_mvm_result_collector;
   import mvm_pkg::*;

   localparam int MS    = 20;
   localparam int DEPTH = 40;

   typedef struct packed {
      logic [15:0] data;
      logic [4:0]  idx;
   } ent_t;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        mvm_done;
   logic [15:0] mvm_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [4:0]  out_index;
   logic        out_last;
   logic        space_avail;
   logic        overflow;
   logic        protocol_err;
   cap_state_t  dbg_state;

   always #5 clk = ~clk;

   mvm_result_collector dut (
      .clk          (clk),
      .reset        (reset),
      .mvm_done     (mvm_done),
      .mvm_data     (mvm_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_index    (out_index),
      .out_last     (out_last),
      .space_avail  (space_avail),
      .overflow     (overflow),
      .protocol_err (protocol_err),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard / model ----------------
   ent_t        exp_q[$];
   bit          m_ovf;
   bit          m_perr;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] bdata [MS];
   int          rdy_mode;
   bit          tog;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit next_rdy();
      bit r;
      case (rdy_mode)
         0:       r = 1'b0;
         1:       r = 1'b1;
         2:       begin tog = !tog; r = tog; end
         default: r = 1'($urandom_range(0, 1));
      endcase
      return r;
   endfunction

   task automatic check_outputs(input bit cap);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("out_data", out_data, exp_q[0].data);
         chk("out_index", out_index, exp_q[0].idx);
         chk("out_last", out_last, exp_q[0].idx == 5'd19);
      end
      chk("space_avail", space_avail, exp_q.size() <= DEPTH - MS);
      chk("overflow", overflow, m_ovf);
      chk("protocol_err", protocol_err, m_perr);
      chk("state", dbg_state, cap ? CAPTURE : IDLE);
   endtask

   // ---------------- driver ----------------
   // One clock cycle: drive inputs, check pre-edge outputs, then apply the
   // buffer rules to the model. cap marks a cycle the burst timing says
   // is a capture cycle for row 'row'.
   task automatic step(input bit done, input logic [15:0] data, input bit rdy,
                       input bit cap, input int row);
      bit full;
      mvm_done  = done;
      mvm_data  = data;
      out_ready = rdy;
      #1;
      check_outputs(cap);
      @(posedge clk);
      full = (exp_q.size() == DEPTH);
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (cap) begin
         if (full) m_ovf = 1'b1;
         else exp_q.push_back('{data: data, idx: 5'(row)});
         if (done) m_perr = 1'b1;
      end
      @(negedge clk);
   endtask

   // done in one cycle, then rows 0..MS-1 in the following cycles.
   task automatic burst(input int perr_row, input int stop_row);
      step(1'b1, 16'h0, next_rdy(), 1'b0, 0);
      for (int j = 0; j < MS; j++) begin
         if (j == stop_row) return;
         step(j == perr_row, bdata[j], next_rdy(), 1'b1, j);
      end
   endtask

   task automatic fill_base(input int base);
      for (int j = 0; j < MS; j++) bdata[j] = 16'(base + j);
   endtask

   task automatic fill_rand();
      for (int j = 0; j < MS; j++) bdata[j] = 16'($urandom);
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) step(1'b0, 16'h0, 1'b1, 1'b0, 0);
      step(1'b0, 16'h0, 1'b1, 1'b0, 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_space"}, space_avail, 1);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_perr"}, protocol_err, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_index"}, out_index, 0);
      chk({tag, "_state"}, dbg_state, IDLE);
   endtask

   initial begin
      #2_000_000;
      $error("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset     = 1'b1;
      mvm_done  = 1'b0;
      mvm_data  = 16'h0;
      out_ready = 1'b1;
      m_ovf     = 1'b0;
      m_perr    = 1'b0;
      tog       = 1'b0;
      rdy_mode  = 1;
      #1;
      check_reset_values("rst");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Single burst, consumer always ready: -7, 1, 2 .. 19.
      repeat (7) step(1'b0, 16'h0, 1'b1, 1'b0, 0);
      fill_base(0);
      bdata[0] = 16'hFFF9;
      burst(-1, -1);
      repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0, 0);

      // Backpressure: two back-to-back bursts with consumer stalled.
      rdy_mode = 0;
      fill_base(100);
      burst(-1, -1);
      fill_base(200);
      burst(-1, -1);
      repeat (3) step(1'b0, 16'h0, 1'b0, 1'b0, 0);
      chk("bp_space", space_avail, 0);
      chk("bp_head", out_data, 100);
      chk("bp_ovf", overflow, 0);

      // Overflow: third burst into a full buffer is dropped.
      fill_rand();
      burst(-1, -1);
      step(1'b0, 16'h0, 1'b0, 1'b0, 0);
      chk("ovf_set", overflow, 1);
      chk("ovf_head", out_data, 100);
      drain();

      // Protocol error: extra done at row 5, random consumer readiness.
      rdy_mode = 3;
      fill_rand();
      burst(5, -1);
      step(1'b0, 16'h0, 1'b0, 1'b0, 0);
      chk("perr_set", protocol_err, 1);
      drain();

      // Reset in the middle of a capture, then a fresh burst.
      fill_rand();
      burst(-1, 7);
      mvm_done = 1'b0;
      reset    = 1'b1;
      #1;
      check_reset_values("midrst");
      exp_q.delete();
      m_ovf  = 1'b0;
      m_perr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 16'h0, 1'b0, 1'b0, 0);
      fill_rand();
      burst(-1, -1);
      drain();

      // Five bursts with ready toggling; the ring wraps several times.
      rdy_mode = 2;
      tog      = 1'b0;
      for (int b = 0; b < 5; b++) begin
         for (int n = 0; n < 100 && !space_avail; n++) step(1'b0, 16'h0, next_rdy(), 1'b0, 0);
         if (!space_avail) chk("space_wait", space_avail, 1);
         fill_rand();
         burst(-1, -1);
      end
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) step(1'b0, 16'h0, next_rdy(), 1'b0, 0);
      drain();
      chk("wrap_ovf", overflow, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mvm_result_collector.md
# mvm_result_collector

Downstream stage of the matrix-vector multiplier. Captures the burst of `MAT_SCALE` result words the MVM emits after `done` and holds them in a ring buffer. Re-presents them on a valid/ready stream, tagged with row index and last flag, so a slow consumer can apply backpressure without losing results. Also tells the upstream controller when it is safe to issue the next `start`.

## Interface
- `MAT_SCALE`, 20, matrix dimension; results per vector
- `INPUT_WIDTH`, 8, MVM operand width
- `OUTPUT_WIDTH`, 2*INPUT_WIDTH, result word width (signed)
- `BUF_VECS`, 2, buffer capacity in whole result vectors; depth = `BUF_VECS*MAT_SCALE`
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `mvm_done`  in  1  MVM `done` strobe
- `mvm_data`  in  OUTPUT_WIDTH  MVM `data_out`, signed
- `out_valid`  out  1  head word available
- `out_ready`  in  1  consumer accepts the head word
- `out_data`  out  OUTPUT_WIDTH  head result word
- `out_index`  out  $clog2(MAT_SCALE)  row index of the head word, 0..MAT_SCALE-1
- `out_last`  out  1  head word is row MAT_SCALE-1
- `space_avail`  out  1  free entries >= MAT_SCALE
- `overflow`  out  1  sticky; a capture found the buffer full
- `protocol_err`  out  1  sticky; `mvm_done` was seen during CAPTURE

## Operation
- Capture FSM has two states: IDLE and CAPTURE.
  - IDLE: `mvm_done`=1 sampled, go to CAPTURE with row counter cleared to 0.
  - CAPTURE: each cycle writes `mvm_data` with the current row index, then increments the counter.
  - CAPTURE: counter = MAT_SCALE-1 returns to IDLE after that write.
- `mvm_done`=1 while in CAPTURE:
  - it is ignored for sequencing;
  - it sets `protocol_err`.
- Ring buffer: write pointer, read pointer and occupancy count; both pointers wrap from depth-1 to 0.
  - Each entry stores {data, index}.
  - `out_last` is derived as index == MAT_SCALE-1.
- Read side:
  - `out_valid` = (count != 0).
  - `out_data`/`out_index` reflect the entry at the read pointer.
  - A pop occurs when `out_valid && out_ready`.
- Same-cycle write and pop: count is unchanged and both pointers advance.
- Full buffer with a write pending:
  - the word is dropped;
  - the write pointer does not move;
  - `overflow` is set.
  - The FSM still steps, so framing stays aligned with the MVM burst.
- `space_avail` is combinational from count: count <= depth-MAT_SCALE.
- No arithmetic on data; words pass through bit-exact, sign preserved.
- Reset (asynchronous, at any time, including mid-CAPTURE):
  - FSM goes to IDLE; pointers, count and counter go to 0.
  - `out_valid`=0, `out_last`=0, `space_avail`=1, `overflow`=0, `protocol_err`=0.
  - `out_data` and `out_index` are 0.
  - A partially captured vector is discarded.

## Timing
- `mvm_done` high in cycle D: row j is captured at the end of cycle D+1+j, for j = 0..MAT_SCALE-1.
- Earliest `out_valid` is cycle D+2: row 0 is visible one cycle after its capture edge.
- With `out_ready` held at 1, row j appears in cycle D+2+j.
  - Throughput is one word per cycle; there are no bubbles.
  - `out_last` is high in cycle D+1+MAT_SCALE.
- A back-to-back `mvm_done` in cycle D+MAT_SCALE+1 (the first IDLE cycle) is accepted.
- `out_*` hold stable while `out_valid && !out_ready`.
- `space_avail` updates in the cycle after the pop or write that changes count.

## Structure
- Shared package `mvm_pkg`:
  - `MAT_SCALE`, `INPUT_WIDTH`, `OUTPUT_WIDTH` defaults;
  - `result_t` (signed OUTPUT_WIDTH);
  - `row_idx_t` ($clog2(MAT_SCALE) bits);
  - capture state enum {IDLE, CAPTURE}.
- One sub-module: `result_ring_fifo`, a parameterised ring FIFO (width, depth) with push/pop/full/count.
  - The collector holds only the capture FSM, the row counter and the sticky flags.

## Test plan
- Single burst with `out_ready`=1:
  - stimulus: `mvm_done` at cycle 10, then `mvm_data` = -7,1,2..19 over cycles 11..30;
  - required: `out_valid` cycles 12..31 with the same data, index 0..19, `out_last` only at cycle 31.
- Backpressure:
  - stimulus: two bursts (data 100+j, then 200+j), `out_ready`=0 throughout;
  - required: count 40, `space_avail`=0, `out_data`=100 held, no `overflow`;
  - then `out_ready`=1 drains all 40 in order.
- Overflow: a third burst with the buffer full; required `overflow`=1, stored data unchanged, readout still 100..219.
- Protocol error: `mvm_done` again at row 5 of a burst; required `protocol_err`=1, burst still ends after 20 words, indices 0..19.
- Reset mid-CAPTURE:
  - stimulus: assert `reset` at row 7, deassert, then a new burst;
  - required: all outputs at reset values immediately, and only the new burst's 20 words are read out.
- Wrap and concurrency:
  - stimulus: 5 consecutive bursts with `out_ready` toggling 1,0 every cycle;
  - required: every word in order, pointers wrap correctly, no `overflow`, `space_avail` correct each cycle.
